slave_fifo_sync_param: RTL and testbench

Parametrised synchronous single-clock FIFO, the successor to the fixed 32x256 FIFO used in the USB slave-FIFO bench and interface. It generalises width and depth, and uses a single occupancy counter so flags and level are coherent. It adds almost-full/almost-empty thresholds, a level output, a read-data valid strobe and defined overflow/underflow rejection. It sits between the USB slave-FIFO interface and the data source or sink.

---
 rtl/slave_fifo_pkg.sv | 13 +
 rtl/slave_fifo_ram.sv | 38 +++
 rtl/slave_fifo_sync_param.sv | 125 ++++++++++++
 tb/tb_slave_fifo_sync_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/slave_fifo_pkg.sv
// Shared constants and helpers for the parametrised slave FIFO.
package slave_fifo_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_MARGIN = 4;

    // Level must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/slave_fifo_ram.sv
// Simple dual-port WIDTH x DEPTH memory: sync write, registered read.
module slave_fifo_ram
    import slave_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/slave_fifo_sync_param.sv
// Parametrised single-clock FIFO with level, thresholds and read strobe.
// Sticky overflow/underflow flags are built only with SLAVE_FIFO_ERR_FLAG_EN.
module slave_fifo_sync_param
    import slave_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - DEF_MARGIN,
    parameter int AE_THRESH = DEF_MARGIN
) (
    input  logic                          fifo_clk,
    input  logic                          reset_,
    input  logic                          fifo_flush,
    input  logic [WIDTH-1:0]              din,
    input  logic                          write_busy,
    input  logic                          read_busy,
    output logic [WIDTH-1:0]              dout,
    output logic                          dout_valid,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow_err,
    output logic                          underflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          valid_q, valid_d;
    logic          wr_acc, rd_acc;

    assign fifo_full    = (level_q == LW'(DEPTH));
    assign fifo_empty   = (level_q == '0);
    assign almost_full  = (level_q >= LW'(AF_THRESH));
    assign almost_empty = (level_q <= LW'(AE_THRESH));
    assign level        = level_q;
    assign dout_valid   = valid_q;

    assign wr_acc = write_busy & ~fifo_full;
    assign rd_acc = read_busy & ~fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        valid_d  = 1'b0;
        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
            valid_d = rd_acc;
        end
    end

    always_ff @(posedge fifo_clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
        end
    end

    // Flush discards any same-cycle access, so the RAM must not see it.
    slave_fifo_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk_i    (fifo_clk),
        .rst_n_i  (reset_),
        .we_i     (wr_acc & ~fifo_flush),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(din),
        .rd_en_i  (rd_acc & ~fifo_flush),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(dout)
    );

`ifdef SLAVE_FIFO_ERR_FLAG_EN
    logic ovf_q, unf_q;

    always_ff @(posedge fifo_clk or negedge reset_) begin
        if (!reset_) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (fifo_flush) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (write_busy && fifo_full) ovf_q <= 1'b1;
            if (read_busy && fifo_empty) unf_q <= 1'b1;
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

`ifndef SYNTHESIS
    always_ff @(posedge fifo_clk) begin
        if (reset_ && !fifo_flush && write_busy && fifo_full)
            $display("%0t slave_fifo: write rejected (full), din=%h", $time, din);
        if (reset_ && !fifo_flush && read_busy && fifo_empty)
            $display("%0t slave_fifo: read rejected (empty), din=%h", $time, din);
    end
`endif
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_slave_fifo_sync_param.sv
// Directed bench: a default 32x256 FIFO and a small 8-deep FIFO.
module tb_slave_fifo_sync_param;

`ifdef SLAVE_FIFO_ERR_FLAG_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic        b_fl, b_wr, b_rd;
    logic [31:0] b_din, b_dout;
    logic        b_vld, b_full, b_emp, b_af, b_ae, b_ovf, b_unf;
    logic [8:0]  b_lvl;

    logic        s_fl, s_wr, s_rd;
    logic [31:0] s_din, s_dout;
    logic        s_vld, s_full, s_emp, s_af, s_ae, s_ovf, s_unf;
    logic [3:0]  s_lvl;

    slave_fifo_sync_param u_big (
        .fifo_clk(clk), .reset_(rst_n), .fifo_flush(b_fl),
        .din(b_din), .write_busy(b_wr), .read_busy(b_rd),
        .dout(b_dout), .dout_valid(b_vld),
        .fifo_full(b_full), .fifo_empty(b_emp),
        .almost_full(b_af), .almost_empty(b_ae), .level(b_lvl),
        .overflow_err(b_ovf), .underflow_err(b_unf)
    );

    slave_fifo_sync_param #(
        .WIDTH(32), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)
    ) u_small (
        .fifo_clk(clk), .reset_(rst_n), .fifo_flush(s_fl),
        .din(s_din), .write_busy(s_wr), .read_busy(s_rd),
        .dout(s_dout), .dout_valid(s_vld),
        .fifo_full(s_full), .fifo_empty(s_emp),
        .almost_full(s_af), .almost_empty(s_ae), .level(s_lvl),
        .overflow_err(s_ovf), .underflow_err(s_unf)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_q [7];

    initial begin
        rst_n = 1'b0;
        {b_fl, b_wr, b_rd, s_fl, s_wr, s_rd} = '0;
        b_din = '0;
        s_din = '0;
        #1;
        chk("rst_empty", b_emp, 1);
        chk("rst_full", b_full, 0);
        chk("rst_ae", b_ae, 1);
        chk("rst_af", b_af, 0);
        chk("rst_level", b_lvl, 0);
        chk("rst_dout", b_dout, 0);
        chk("rst_valid", b_vld, 0);
        chk("rst_ovf", b_ovf, 0);
        chk("rst_unf", b_unf, 0);
        tick;
        rst_n = 1'b1;
        tick;

        // fill the 256-deep FIFO
        b_wr = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b_din = i;
            tick;
            if (i == 251) chk("big_af_252", b_af, 1);
            if (i == 254) chk("big_full_255", b_full, 0);
        end
        chk("big_full", b_full, 1);
        chk("big_level", b_lvl, 256);
        b_din = 32'hDEAD_BEEF;
        tick;
        b_wr = 1'b0;
        chk("big_257_level", b_lvl, 256);
        chk("big_ovf", b_ovf, ERR_EN);

        b_rd = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick;
            chk("big_drain_dout", b_dout, i);
            chk("big_drain_vld", b_vld, 1);
        end
        chk("big_empty", b_emp, 1);
        chk("big_level0", b_lvl, 0);
        tick;
        b_rd = 1'b0;
        chk("big_unf_vld", b_vld, 0);
        chk("big_unf", b_unf, ERR_EN);
        chk("big_hold_dout", b_dout, 255);
        tick;
        chk("big_unf_held", b_unf, ERR_EN);

        // thresholds on the 8-deep FIFO
        s_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_din = 32'h100 + i;
            tick;
            if (i == 0) chk("s_ae_l1", s_ae, 1);
            if (i == 1) chk("s_ae_l2", s_ae, 0);
            if (i == 4) chk("s_af_l5", s_af, 0);
        end
        s_wr = 1'b0;
        chk("s_af_l6", s_af, 1);
        chk("s_level6", s_lvl, 6);
        s_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("s_rd_dout", s_dout, 32'h100 + i);
            if (i == 3) chk("s_ae_l2r", s_ae, 0);
        end
        s_rd = 1'b0;
        chk("s_ae_l1r", s_ae, 1);
        chk("s_level1", s_lvl, 1);

        // fill, then simultaneous read/write while full
        s_wr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_din = 32'h200 + i;
            tick;
        end
        chk("s_full", s_full, 1);
        chk("s_level8", s_lvl, 8);
        s_rd = 1'b1;
        s_din = 32'h300;
        tick;
        chk("s_rw1_level", s_lvl, 7);
        chk("s_rw1_dout", s_dout, 32'h105);
        chk("s_ovf", s_ovf, ERR_EN);
        s_din = 32'h301;
        tick;
        chk("s_rw2_level", s_lvl, 7);
        chk("s_rw2_dout", s_dout, 32'h200);
        s_din = 32'h302;
        tick;
        chk("s_rw3_level", s_lvl, 7);
        chk("s_rw3_dout", s_dout, 32'h201);
        s_wr = 1'b0;
        exp_q = '{32'h202, 32'h203, 32'h204, 32'h205,
                  32'h206, 32'h301, 32'h302};
        for (int i = 0; i < 7; i++) begin
            tick;
            chk("s_drain_dout", s_dout, exp_q[i]);
        end
        s_rd = 1'b0;
        chk("s_drain_empty", s_emp, 1);

        // simultaneous on empty: no bypass
        s_wr = 1'b1;
        s_rd = 1'b1;
        s_din = 32'hA5A5_A5A5;
        tick;
        s_wr = 1'b0;
        chk("s_emp_vld", s_vld, 0);
        chk("s_emp_dout", s_dout, 32'h302);
        chk("s_emp_level", s_lvl, 1);
        chk("s_emp_unf", s_unf, ERR_EN);
        tick;
        s_rd = 1'b0;
        chk("s_a5_dout", s_dout, 32'hA5A5_A5A5);
        chk("s_a5_vld", s_vld, 1);

        // flush with a concurrent write
        s_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_din = 32'h400 + i;
            tick;
        end
        chk("s_pre_flush", s_lvl, 5);
        s_fl = 1'b1;
        s_din = 32'h0BAD;
        tick;
        s_fl = 1'b0;
        s_wr = 1'b0;
        chk("fl_level", s_lvl, 0);
        chk("fl_empty", s_emp, 1);
        chk("fl_vld", s_vld, 0);
        chk("fl_dout_hold", s_dout, 32'hA5A5_A5A5);
        chk("fl_ovf", s_ovf, 0);
        chk("fl_unf", s_unf, 0);
        s_wr = 1'b1;
        s_din = 32'h1234_5678;
        tick;
        s_wr = 1'b0;
        s_rd = 1'b1;
        tick;
        s_rd = 1'b0;
        chk("fl_rt_dout", s_dout, 32'h1234_5678);
        chk("fl_rt_vld", s_vld, 1);
        chk("fl_rt_level", s_lvl, 0);

        // async reset mid-stream
        s_wr = 1'b1;
        s_din = 32'h77;
        tick;
        tick;
        s_wr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_level", s_lvl, 0);
        chk("ar_empty", s_emp, 1);
        chk("ar_dout", s_dout, 0);
        chk("ar_vld", s_vld, 0);
        chk("ar_ae", s_ae, 1);
        chk("ar_unf_big", b_unf, 0);
        tick;
        rst_n = 1'b1;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
